mop_sequencer: RTL

Micro-op sequencer for multi-register load/store macro-ops (mops) in the ID stage. Accepts one decoded mop (base register, register mask, offset, direction) and emits one single-register load/store micro-op per cycle into the ID/EX path. Its `busy` output drives the hazard unit's `id_have_mop` input, so fetch/decode stalls while a mop is expanding. It obeys the hazard unit's `load_stall` (as `hold`) and `flush`.

---
 rtl/mop_sequencer_pkg.sv | 25 ++
 rtl/mop_sequencer_if.sv | 53 +++++
 rtl/mop_sequencer_ffs.sv | 32 +++
 rtl/mop_sequencer.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mop_sequencer_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : mop_pkg
//  Purpose  : Shared constants and the state encoding for the micro-op
//             sequencer.
//             - MOP_REG_W  : register index width
//             - MOP_MASK_W : register-list mask width
//             - MOP_IMM_W  : immediate width
//             - mop_state_t: IDLE / ISSUE / EMPTY
//  Revision : 1.0 - initial release
// ============================================================================
package mop_pkg;

    localparam int MOP_REG_W  = 6;
    localparam int MOP_MASK_W = 16;
    localparam int MOP_IMM_W  = 12;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        EMPTY = 2'd2
    } mop_state_t;

endpackage : mop_pkg
`default_nettype wire

// File: rtl/mop_sequencer_if.sv
`default_nettype none
// ============================================================================
//  Module   : mop_sequencer_if
//  Purpose  : Bundles the decoded-mop handshake, pipeline control and the
//             emitted micro-op bus of the sequencer.
//             slave  : the sequencer (consumes mop_*, hold, flush; drives
//                      mop_ready, uop_*, busy)
//             master : the decode / pipeline side
//  Revision : 1.0 - initial release
// ============================================================================
interface mop_sequencer_if
    import mop_pkg::*;
#(
    parameter int REG_W  = MOP_REG_W,
    parameter int MASK_W = MOP_MASK_W,
    parameter int IMM_W  = MOP_IMM_W
);
    // decoded mop handshake
    logic              mop_valid;
    logic              mop_ready;
    logic              mop_load;
    logic [REG_W-1:0]  mop_base;
    logic [REG_W-1:0]  mop_rlo;
    logic [MASK_W-1:0] mop_mask;
    logic [IMM_W-1:0]  mop_offset;
    // pipeline control from the hazard unit
    logic              hold;
    logic              flush;
    // emitted micro-op
    logic              uop_valid;
    logic              uop_load;
    logic [REG_W-1:0]  uop_rs1;
    logic [REG_W-1:0]  uop_reg;
    logic [IMM_W-1:0]  uop_imm;
    logic              uop_last;
    logic              busy;

    modport slave (
        input  mop_valid, mop_load, mop_base, mop_rlo, mop_mask, mop_offset,
        input  hold, flush,
        output mop_ready,
        output uop_valid, uop_load, uop_rs1, uop_reg, uop_imm, uop_last, busy
    );

    modport master (
        output mop_valid, mop_load, mop_base, mop_rlo, mop_mask, mop_offset,
        output hold, flush,
        input  mop_ready,
        input  uop_valid, uop_load, uop_rs1, uop_reg, uop_imm, uop_last, busy
    );

endinterface : mop_sequencer_if
`default_nettype wire

// File: rtl/mop_sequencer_ffs.sv
`default_nettype none
// ============================================================================
//  Module   : mop_ffs
//  Purpose  : Lowest-set-bit priority encoder.
//             i_vec : W-bit input vector
//             o_idx : index of the lowest set bit (0 when none set)
//             o_any : at least one bit of i_vec is set
//  Revision : 1.0 - initial release
// ============================================================================
module mop_ffs #(
    parameter int W     = 16,
    parameter int IDX_W = (W > 1) ? $clog2(W) : 1
) (
    input  logic [W-1:0]     i_vec,
    output logic [IDX_W-1:0] o_idx,
    output logic             o_any
);

    // Scan from the top down so the last hit is the lowest set bit.
    always_comb begin
        o_idx = '0;
        for (int i = W - 1; i >= 0; i--) begin
            if (i_vec[i]) begin
                o_idx = IDX_W'(i);
            end
        end
    end

    assign o_any = |i_vec;

endmodule : mop_ffs
`default_nettype wire

// File: rtl/mop_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : mop_sequencer
//  Purpose  : Expands one multi-register load/store macro-op into a stream of
//             single-register micro-ops, one per cycle, for the ID/EX path.
//  Ports    : clk  - clock
//             rst  - synchronous active-high reset
//             bus  - mop_sequencer_if.slave:
//                    mop_valid/mop_ready/mop_load/mop_base/mop_rlo/mop_mask/
//                    mop_offset  : decoded mop handshake
//                    hold / flush: hazard-unit stall and abort
//                    uop_valid/uop_load/uop_rs1/uop_reg/uop_imm/uop_last
//                                : registered micro-op
//                    busy        : expansion in progress (id_have_mop)
//  Revision : 1.0 - initial release
// ============================================================================
module mop_sequencer
    import mop_pkg::*;
#(
    parameter int REG_W  = MOP_REG_W,
    parameter int MASK_W = MOP_MASK_W,
    parameter int IMM_W  = MOP_IMM_W
) (
    input  logic            clk,
    input  logic            rst,
    mop_sequencer_if.slave  bus
);

    localparam int IDX_W  = (MASK_W > 1) ? $clog2(MASK_W) : 1;
    localparam int RANK_W = $clog2(MASK_W + 1);

    // ------------------------------------------------------------------
    // State and latched mop
    // ------------------------------------------------------------------
    mop_state_t         r_state;
    mop_state_t         w_nxt_state;

    logic               r_load;
    logic [REG_W-1:0]   r_base;
    logic [REG_W-1:0]   r_rlo;
    logic [MASK_W-1:0]  r_mask_orig;
    logic [MASK_W-1:0]  r_mask_rem;     // bits not yet presented on uop_*
    logic [IMM_W-1:0]   r_offset;
    logic               r_defer;

    // registered outputs
    logic               r_uop_valid;
    logic               r_uop_load;
    logic [REG_W-1:0]   r_uop_rs1;
    logic [REG_W-1:0]   r_uop_reg;
    logic [IMM_W-1:0]   r_uop_imm;
    logic               r_uop_last;
    logic               r_busy;

    // ------------------------------------------------------------------
    // Source selection: the first uop is computed straight from the bus
    // during the accept cycle so it is on the outputs the cycle after;
    // later uops come from the latched copy.
    // ------------------------------------------------------------------
    logic               w_src_load;
    logic [REG_W-1:0]   w_src_base;
    logic [REG_W-1:0]   w_src_rlo;
    logic [MASK_W-1:0]  w_src_mask;
    logic [MASK_W-1:0]  w_src_orig;
    logic [IMM_W-1:0]   w_src_offset;
    logic               w_src_defer;

    logic [MASK_W-1:0]  w_base_oh;
    logic               w_acc_defer;
    logic [MASK_W-1:0]  w_pref;
    logic [MASK_W-1:0]  w_pick;
    logic [IDX_W-1:0]   w_idx;
    logic               w_any;
    logic [RANK_W-1:0]  w_rank;
    logic [REG_W-1:0]   w_emit_reg;
    logic [IMM_W-1:0]   w_emit_imm;
    logic [MASK_W-1:0]  w_rem_next;

    always_comb begin
        if (r_state == IDLE) begin
            w_src_load   = bus.mop_load;
            w_src_base   = bus.mop_base;
            w_src_rlo    = bus.mop_rlo;
            w_src_mask   = bus.mop_mask;
            w_src_orig   = bus.mop_mask;
            w_src_offset = bus.mop_offset;
        end else begin
            w_src_load   = r_load;
            w_src_base   = r_base;
            w_src_rlo    = r_rlo;
            w_src_mask   = r_mask_rem;
            w_src_orig   = r_mask_orig;
            w_src_offset = r_offset;
        end
    end

    // Mask position(s) that name the base register; index math wraps.
    always_comb begin
        w_base_oh = '0;
        for (int i = 0; i < MASK_W; i++) begin
            w_base_oh[i] = ((w_src_rlo + REG_W'(i)) == w_src_base);
        end
    end

    // A load that overwrites its own base must write it last.
    assign w_acc_defer = bus.mop_load & (|(bus.mop_mask & w_base_oh));
    assign w_src_defer = (r_state == IDLE) ? w_acc_defer : r_defer;

    // Skip the base bit while anything else remains.
    assign w_pref = w_src_mask & ~(w_src_defer ? w_base_oh : '0);
    assign w_pick = (|w_pref) ? w_pref : w_src_mask;

    mop_ffs #(
        .W     (MASK_W),
        .IDX_W (IDX_W)
    ) u_ffs (
        .i_vec (w_pick),
        .o_idx (w_idx),
        .o_any (w_any)
    );

    // Slot rank counts against the original list, so a deferred base
    // still uses the offset of its natural position.
    always_comb begin
        w_rank = '0;
        for (int i = 0; i < MASK_W; i++) begin
            if ((i < int'(w_idx)) && w_src_orig[i]) begin
                w_rank = w_rank + RANK_W'(1);
            end
        end
    end

    assign w_emit_reg = w_src_rlo + REG_W'(w_idx);
    assign w_emit_imm = w_src_offset + (IMM_W'(w_rank) << 2);
    assign w_rem_next = w_src_mask & ~(MASK_W'(1) << w_idx);

    // ------------------------------------------------------------------
    // FSM next-state and datapath actions
    // ------------------------------------------------------------------
    logic w_do_latch;
    logic w_do_emit;
    logic w_go_empty;
    logic w_do_clear;

    always_comb begin
        w_nxt_state = r_state;
        w_do_latch  = 1'b0;
        w_do_emit   = 1'b0;
        w_go_empty  = 1'b0;
        w_do_clear  = 1'b0;

        case (r_state)
            IDLE: begin
                w_do_clear = 1'b1;
                if (bus.mop_valid) begin
                    w_do_latch = 1'b1;
                    if (w_any) begin
                        w_nxt_state = ISSUE;
                        w_do_emit   = 1'b1;
                    end else begin
                        w_nxt_state = EMPTY;
                        w_go_empty  = 1'b1;
                    end
                end
            end
            ISSUE: begin
                // hold freezes everything, including the presented uop
                if (!bus.hold) begin
                    if (w_any) begin
                        w_do_emit = 1'b1;
                    end else begin
                        w_nxt_state = IDLE;
                        w_do_clear  = 1'b1;
                    end
                end
            end
            EMPTY: begin
                w_nxt_state = IDLE;
                w_do_clear  = 1'b1;
            end
            default: begin
                w_nxt_state = IDLE;
                w_do_clear  = 1'b1;
            end
        endcase

        // flush aborts from any state and beats both hold and mop_valid
        if (bus.flush) begin
            w_nxt_state = IDLE;
            w_do_latch  = 1'b0;
            w_do_emit   = 1'b0;
            w_go_empty  = 1'b0;
            w_do_clear  = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_load      <= 1'b0;
            r_base      <= '0;
            r_rlo       <= '0;
            r_mask_orig <= '0;
            r_mask_rem  <= '0;
            r_offset    <= '0;
            r_defer     <= 1'b0;
            r_uop_valid <= 1'b0;
            r_uop_load  <= 1'b0;
            r_uop_rs1   <= '0;
            r_uop_reg   <= '0;
            r_uop_imm   <= '0;
            r_uop_last  <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_state <= w_nxt_state;

            if (w_do_latch) begin
                r_load      <= bus.mop_load;
                r_base      <= bus.mop_base;
                r_rlo       <= bus.mop_rlo;
                r_mask_orig <= bus.mop_mask;
                r_offset    <= bus.mop_offset;
                r_defer     <= w_acc_defer;
            end

            if (w_do_emit) begin
                r_uop_valid <= 1'b1;
                r_uop_load  <= w_src_load;
                r_uop_rs1   <= w_src_base;
                r_uop_reg   <= w_emit_reg;
                r_uop_imm   <= w_emit_imm;
                r_uop_last  <= (w_rem_next == '0);
                r_busy      <= 1'b1;
                r_mask_rem  <= w_rem_next;
            end else if (w_go_empty || w_do_clear) begin
                r_uop_valid <= 1'b0;
                r_uop_load  <= 1'b0;
                r_uop_rs1   <= '0;
                r_uop_reg   <= '0;
                r_uop_imm   <= '0;
                r_uop_last  <= 1'b0;
                r_busy      <= w_go_empty;
                r_mask_rem  <= '0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign bus.mop_ready = (r_state == IDLE);
    assign bus.uop_valid = r_uop_valid;
    assign bus.uop_load  = r_uop_load;
    assign bus.uop_rs1   = r_uop_rs1;
    assign bus.uop_reg   = r_uop_reg;
    assign bus.uop_imm   = r_uop_imm;
    assign bus.uop_last  = r_uop_last;
    assign bus.busy      = r_busy;

endmodule : mop_sequencer
`default_nettype wire
